chip8_sound_gen: RTL and testbench

Audio back-end that consumes the 8-bit sound-timer value from the CHIP-8 timer stage and produces the buzzer signal.
- While the sound value is nonzero and output is enabled, it generates a fixed-pitch square tone.
- The tone is amplitude-shaped by a linear attack/release envelope so that start and stop are click-free.
- Two outputs: a raw square (for a piezo) and a PWM-modulated square (for an RC-filtered speaker).

---
 rtl/chip8_pkg.sv | 18 +
 rtl/chip8_pwm.sv | 29 ++
 rtl/chip8_sound_gen.sv | 146 ++++++++++++++
 tb/tb_chip8_sound_gen.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/chip8_pkg.sv
// Shared types and helpers for the CHIP-8 sound generator.
//   snd_state_e : envelope FSM state (2-bit encoding)
//   amp_max()   : full-scale amplitude for a given amplitude width
package chip8_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StAttack  = 2'd1,
    StSustain = 2'd2,
    StRelease = 2'd3
  } snd_state_e;

  // All-ones value for a w-bit amplitude (w <= 31).
  function automatic logic [31:0] amp_max(input int unsigned w);
    return (32'd1 << w) - 32'd1;
  endfunction

endpackage

// File: rtl/chip8_pwm.sv
// Free-running PWM comparator.
//   i_clk, i_reset_n : clock, asynchronous active-low reset
//   i_tone           : square-tone gate; pwm is forced low while it is low
//   i_amp            : duty setting; output high while counter < i_amp
//   o_pwm            : i_tone AND (counter < i_amp)
module chip8_pwm #(
  parameter int unsigned AMP_W = 8
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_tone,
  input  logic [AMP_W-1:0] i_amp,
  output logic             o_pwm
);

  logic [AMP_W-1:0] r_cnt;

  // Wraps all-ones -> 0 naturally through unsigned overflow.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_pwm = i_tone & (r_cnt < i_amp);

endmodule

// File: rtl/chip8_sound_gen.sv
// CHIP-8 buzzer back-end: envelope-shaped fixed-pitch square tone.
//   i_clk        : system clock
//   i_reset_n    : asynchronous active-low reset
//   i_sound_val  : sound-timer value; nonzero requests a tone
//   i_enable     : master audio enable; low forces release
//   o_tone_out   : raw square tone, low in IDLE
//   o_pwm_out    : tone gated by PWM at the envelope amplitude
//   o_amp        : current envelope amplitude
//   o_active     : high in any state other than IDLE
module chip8_sound_gen
  import chip8_pkg::*;
#(
  parameter int unsigned TONE_DIV  = 25000,
  parameter int unsigned RAMP_STEP = 256,
  parameter int unsigned AMP_W     = 8
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic [7:0]       i_sound_val,
  input  logic             i_enable,
  output logic             o_tone_out,
  output logic             o_pwm_out,
  output logic [AMP_W-1:0] o_amp,
  output logic             o_active
);

  localparam int unsigned TONE_W = $clog2(TONE_DIV);
  localparam int unsigned RAMP_W = (RAMP_STEP > 1) ? $clog2(RAMP_STEP) : 1;

  localparam logic [AMP_W-1:0]  AmpMax   = AMP_W'(amp_max(AMP_W));
  localparam logic [AMP_W-1:0]  AmpOne   = AMP_W'(1);
  localparam logic [TONE_W-1:0] ToneLast = TONE_W'(TONE_DIV - 1);
  localparam logic [RAMP_W-1:0] RampLast = RAMP_W'(RAMP_STEP - 1);

  snd_state_e        r_state;
  logic [AMP_W-1:0]  r_amp;
  logic [RAMP_W-1:0] r_ramp_cnt;
  logic [TONE_W-1:0] r_tone_cnt;
  logic              r_phase;
  logic              r_active;
  logic              w_req;

  assign w_req = (i_sound_val != 8'd0) && i_enable;

  // Later non-blocking assignments in the FSM override the tone-divider
  // defaults, so entering IDLE clears the divider on the same edge.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state    <= StIdle;
      r_amp      <= '0;
      r_ramp_cnt <= '0;
      r_tone_cnt <= '0;
      r_phase    <= 1'b0;
      r_active   <= 1'b0;
    end else begin
      // Tone divider: runs outside IDLE, first half-period is low.
      if (r_state == StIdle) begin
        r_tone_cnt <= '0;
        r_phase    <= 1'b0;
      end else if (r_tone_cnt == ToneLast) begin
        r_tone_cnt <= '0;
        r_phase    <= ~r_phase;
      end else begin
        r_tone_cnt <= r_tone_cnt + 1'b1;
      end

      // Envelope FSM. A req change wins over a ramp step in the same cycle.
      case (r_state)
        StIdle: begin
          if (w_req) begin
            r_state    <= StAttack;
            r_active   <= 1'b1;
            r_ramp_cnt <= '0;
          end
        end
        StAttack: begin
          if (!w_req) begin
            r_state    <= StRelease;
            r_ramp_cnt <= '0;
          end else if (r_amp == AmpMax) begin
            // Reachable when retriggered before the first release step.
            r_state    <= StSustain;
            r_ramp_cnt <= '0;
          end else if (r_ramp_cnt == RampLast) begin
            r_amp      <= r_amp + 1'b1;
            r_ramp_cnt <= '0;
            if (r_amp == AmpMax - AmpOne) r_state <= StSustain;
          end else begin
            r_ramp_cnt <= r_ramp_cnt + 1'b1;
          end
        end
        StSustain: begin
          if (!w_req) begin
            r_state    <= StRelease;
            r_ramp_cnt <= '0;
          end
        end
        StRelease: begin
          if (w_req) begin
            r_state    <= StAttack;
            r_ramp_cnt <= '0;
          end else if (r_amp == '0) begin
            // Reachable when req drops before the first attack step.
            r_state    <= StIdle;
            r_active   <= 1'b0;
            r_ramp_cnt <= '0;
            r_tone_cnt <= '0;
            r_phase    <= 1'b0;
          end else if (r_ramp_cnt == RampLast) begin
            r_amp      <= r_amp - 1'b1;
            r_ramp_cnt <= '0;
            if (r_amp == AmpOne) begin
              r_state    <= StIdle;
              r_active   <= 1'b0;
              r_tone_cnt <= '0;
              r_phase    <= 1'b0;
            end
          end else begin
            r_ramp_cnt <= r_ramp_cnt + 1'b1;
          end
        end
        default: begin
          r_state    <= StIdle;
          r_active   <= 1'b0;
          r_amp      <= '0;
          r_ramp_cnt <= '0;
        end
      endcase
    end
  end

  chip8_pwm #(
    .AMP_W(AMP_W)
  ) u_pwm (
    .i_clk    (i_clk),
    .i_reset_n(i_reset_n),
    .i_tone   (r_phase),
    .i_amp    (r_amp),
    .o_pwm    (o_pwm_out)
  );

  assign o_tone_out = r_phase;
  assign o_amp      = r_amp;
  assign o_active   = r_active;

endmodule

// File: tb/tb_chip8_sound_gen.sv
// Directed bench for chip8_sound_gen with TONE_DIV=4, RAMP_STEP=2, AMP_W=8.
// Cycle n counts posedges since the sound request was applied (edge 1 enters
// ATTACK). Attack: amp = (n-1)/2; tone = ((n-1)/4) mod 2.
module tb_chip8_sound_gen;

  logic       clk;
  logic       rst_n;
  logic [7:0] sv;
  logic       en;
  logic       tone;
  logic       pwm;
  logic [7:0] amp;
  logic       active;

  int n_asserts;
  int n_fail;
  int edge_cnt;

  chip8_sound_gen #(
    .TONE_DIV (4),
    .RAMP_STEP(2),
    .AMP_W    (8)
  ) dut (
    .i_clk      (clk),
    .i_reset_n  (rst_n),
    .i_sound_val(sv),
    .i_enable   (en),
    .o_tone_out (tone),
    .o_pwm_out  (pwm),
    .o_amp      (amp),
    .o_active   (active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference for the free-running PWM counter.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) edge_cnt <= 0;
    else        edge_cnt <= edge_cnt + 1;
  end

  task automatic do_reset();
    rst_n = 1'b0;
    sv    = 8'd0;
    en    = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    sv    = 8'hFF;
    en    = 1'b1;
    repeat (3) @(negedge clk);
    n_asserts += 4;
    if (amp !== 8'd0) begin n_fail++; $display("FAIL reset amp got %0d exp 0", amp); end
    if (tone !== 1'b0) begin n_fail++; $display("FAIL reset tone got %b exp 0", tone); end
    if (pwm !== 1'b0) begin n_fail++; $display("FAIL reset pwm got %b exp 0", pwm); end
    if (active !== 1'b0) begin n_fail++; $display("FAIL reset active got %b exp 0", active); end
    rst_n = 1'b1;
    #1;
    n_asserts++;
    if (active !== 1'b0) begin n_fail++; $display("FAIL reset_rel_pre active got %b exp 0", active); end
    @(negedge clk);
    n_asserts += 3;
    if (active !== 1'b1) begin n_fail++; $display("FAIL reset_rel active got %b exp 1", active); end
    if (amp !== 8'd0) begin n_fail++; $display("FAIL reset_rel amp got %0d exp 0", amp); end
    if (tone !== 1'b0) begin n_fail++; $display("FAIL reset_rel tone got %b exp 0", tone); end
  endtask

  task automatic test_full_attack();
    int ea;
    logic et, ep;
    do_reset();
    sv = 8'd200;
    for (int n = 1; n <= 520; n++) begin
      @(negedge clk);
      ea = (n - 1) / 2;
      if (ea > 255) ea = 255;
      et = 1'(((n - 1) / 4) % 2);
      ep = et && ((edge_cnt % 256) < ea);
      n_asserts += 4;
      if (amp !== 8'(ea)) begin n_fail++; $display("FAIL attack amp n=%0d got %0d exp %0d", n, amp, ea); end
      if (tone !== et) begin n_fail++; $display("FAIL attack tone n=%0d got %b exp %b", n, tone, et); end
      if (pwm !== ep) begin n_fail++; $display("FAIL attack pwm n=%0d got %b exp %b", n, pwm, ep); end
      if (active !== 1'b1) begin n_fail++; $display("FAIL attack active n=%0d got %b exp 1", n, active); end
    end
  endtask

  task automatic test_early_release();
    int ea, n;
    logic et, ep, eact;
    do_reset();
    sv = 8'd200;
    repeat (21) @(negedge clk);
    n_asserts++;
    if (amp !== 8'd10) begin n_fail++; $display("FAIL early_pre amp got %0d exp 10", amp); end
    sv = 8'd0;
    for (int j = 0; j < 30; j++) begin
      @(negedge clk);
      n    = 22 + j;
      ea   = (j / 2 >= 10) ? 0 : 10 - j / 2;
      eact = (j < 20);
      et   = eact ? 1'(((n - 1) / 4) % 2) : 1'b0;
      ep   = et && ((edge_cnt % 256) < ea);
      n_asserts += 4;
      if (amp !== 8'(ea)) begin n_fail++; $display("FAIL early amp j=%0d got %0d exp %0d", j, amp, ea); end
      if (active !== eact) begin n_fail++; $display("FAIL early active j=%0d got %b exp %b", j, active, eact); end
      if (tone !== et) begin n_fail++; $display("FAIL early tone j=%0d got %b exp %b", j, tone, et); end
      if (pwm !== ep) begin n_fail++; $display("FAIL early pwm j=%0d got %b exp %b", j, pwm, ep); end
    end
  endtask

  task automatic test_retrigger();
    int ea, n;
    logic et;
    do_reset();
    sv = 8'd200;
    repeat (205) @(negedge clk);
    sv = 8'd0;
    repeat (6) @(negedge clk);
    // Edge 211: RELEASE, amp 100, ramp mid-step; reassert before the decrement.
    n_asserts++;
    if (amp !== 8'd100) begin n_fail++; $display("FAIL retrig_pre amp got %0d exp 100", amp); end
    sv = 8'd3;
    for (int m = 0; m <= 20; m++) begin
      @(negedge clk);
      n  = 212 + m;
      ea = 100 + m / 2;
      et = 1'(((n - 1) / 4) % 2);
      n_asserts += 3;
      if (amp !== 8'(ea)) begin n_fail++; $display("FAIL retrig amp m=%0d got %0d exp %0d", m, amp, ea); end
      if (tone !== et) begin n_fail++; $display("FAIL retrig tone m=%0d got %b exp %b", m, tone, et); end
      if (active !== 1'b1) begin n_fail++; $display("FAIL retrig active m=%0d got %b exp 1", m, active); end
    end
  endtask

  task automatic test_disable();
    int ea, n;
    logic et, ep, eact;
    do_reset();
    sv = 8'd50;
    repeat (515) @(negedge clk);
    n_asserts++;
    if (amp !== 8'd255) begin n_fail++; $display("FAIL disable_pre amp got %0d exp 255", amp); end
    en = 1'b0;
    for (int j = 0; j < 516; j++) begin
      @(negedge clk);
      n    = 516 + j;
      ea   = (j >= 510) ? 0 : 255 - j / 2;
      eact = (j < 510);
      et   = eact ? 1'(((n - 1) / 4) % 2) : 1'b0;
      ep   = et && ((edge_cnt % 256) < ea);
      n_asserts += 4;
      if (amp !== 8'(ea)) begin n_fail++; $display("FAIL disable amp j=%0d got %0d exp %0d", j, amp, ea); end
      if (active !== eact) begin n_fail++; $display("FAIL disable active j=%0d got %b exp %b", j, active, eact); end
      if (tone !== et) begin n_fail++; $display("FAIL disable tone j=%0d got %b exp %b", j, tone, et); end
      if (pwm !== ep) begin n_fail++; $display("FAIL disable pwm j=%0d got %b exp %b", j, pwm, ep); end
    end
  endtask

  task automatic test_reenable();
    int ea, n;
    logic et;
    do_reset();
    sv = 8'd50;
    repeat (515) @(negedge clk);
    en = 1'b0;
    repeat (301) @(negedge clk);
    n_asserts++;
    if (amp !== 8'd105) begin n_fail++; $display("FAIL reenable_pre amp got %0d exp 105", amp); end
    en = 1'b1;
    for (int m = 0; m <= 20; m++) begin
      @(negedge clk);
      n  = 817 + m;
      ea = 105 + m / 2;
      et = 1'(((n - 1) / 4) % 2);
      n_asserts += 3;
      if (amp !== 8'(ea)) begin n_fail++; $display("FAIL reenable amp m=%0d got %0d exp %0d", m, amp, ea); end
      if (tone !== et) begin n_fail++; $display("FAIL reenable tone m=%0d got %b exp %b", m, tone, et); end
      if (active !== 1'b1) begin n_fail++; $display("FAIL reenable active m=%0d got %b exp 1", m, active); end
    end
  endtask

  task automatic test_reset_mid_tone();
    do_reset();
    sv = 8'd50;
    repeat (517) @(negedge clk);
    n_asserts += 2;
    if (tone !== 1'b1) begin n_fail++; $display("FAIL midrst_pre tone got %b exp 1", tone); end
    if (amp !== 8'd255) begin n_fail++; $display("FAIL midrst_pre amp got %0d exp 255", amp); end
    #2;
    rst_n = 1'b0;
    #1;
    n_asserts += 4;
    if (amp !== 8'd0) begin n_fail++; $display("FAIL midrst amp got %0d exp 0", amp); end
    if (tone !== 1'b0) begin n_fail++; $display("FAIL midrst tone got %b exp 0", tone); end
    if (pwm !== 1'b0) begin n_fail++; $display("FAIL midrst pwm got %b exp 0", pwm); end
    if (active !== 1'b0) begin n_fail++; $display("FAIL midrst active got %b exp 0", active); end
    @(posedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    @(negedge clk);
    n_asserts += 3;
    if (active !== 1'b1) begin n_fail++; $display("FAIL midrst_resume active got %b exp 1", active); end
    if (amp !== 8'd0) begin n_fail++; $display("FAIL midrst_resume amp got %0d exp 0", amp); end
    if (tone !== 1'b0) begin n_fail++; $display("FAIL midrst_resume tone got %b exp 0", tone); end
    repeat (2) @(negedge clk);
    n_asserts++;
    if (amp !== 8'd1) begin n_fail++; $display("FAIL midrst_climb amp got %0d exp 1", amp); end
  endtask

  initial begin
    n_asserts = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    sv        = 8'd0;
    en        = 1'b0;
    test_reset();
    test_full_attack();
    test_early_release();
    test_retrigger();
    test_disable();
    test_reenable();
    test_reset_mid_tone();
    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
